// File: rtl/alu_divider.sv
// Multi-cycle radix-2 restoring divide/modulo unit beside the execute-stage ALU.
// Works on operand magnitudes, then fixes signs and selects quotient or remainder.
module alu_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  opcode,
    input  logic        start,
    input  logic        flush,
    output logic [31:0] y,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] divisor_q, divisor_d;
    logic [31:0] origA_q, origA_d;
    logic [5:0]  iterCnt_q, iterCnt_d;
    logic        negQuot_q, negQuot_d;
    logic        negRem_q, negRem_d;
    logic        divZero_q, divZero_d;
    logic        isMod_q, isMod_d;
    logic [31:0] y_q, y_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        accept;
    logic        opSigned;
    logic [31:0] magA, magB;
    logic [32:0] shifted, diff;
    logic [31:0] quotRes, remRes;

    // Opcode bit 0 selects unsigned, bit 1 selects remainder.
    assign opSigned = ~opcode[0];
    assign magA     = (opSigned && a[31]) ? (~a + 32'd1) : a;
    assign magB     = (opSigned && b[31]) ? (~b + 32'd1) : b;
    assign accept   = start && ((state_q == IDLE) || (state_q == DONE));

    // Remainder stays below the divisor, so the shifted value fits in 33 bits.
    assign shifted  = {rem_q, quot_q[31]};
    assign diff     = shifted - {1'b0, divisor_q};

    always_comb begin
        quotRes = negQuot_q ? (~quot_q + 32'd1) : quot_q;
        remRes  = negRem_q  ? (~rem_q + 32'd1)  : rem_q;
        if (divZero_q) begin
            quotRes = 32'hFFFF_FFFF;
            remRes  = origA_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        origA_d   = origA_q;
        iterCnt_d = iterCnt_q;
        negQuot_d = negQuot_q;
        negRem_d  = negRem_q;
        divZero_d = divZero_q;
        isMod_d   = isMod_q;
        y_d       = y_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    state_d   = CALC;
                    rem_d     = 32'd0;
                    quot_d    = magA;
                    divisor_d = magB;
                    origA_d   = a;
                    iterCnt_d = 6'd0;
                    negQuot_d = opSigned & (a[31] ^ b[31]);
                    negRem_d  = opSigned & a[31];
                    divZero_d = (b == 32'd0);
                    isMod_d   = opcode[1];
                end
            end
            CALC: begin
                if (!diff[32]) begin
                    rem_d  = diff[31:0];
                    quot_d = {quot_q[30:0], 1'b1};
                end else begin
                    rem_d  = shifted[31:0];
                    quot_d = {quot_q[30:0], 1'b0};
                end
                iterCnt_d = iterCnt_q + 6'd1;
                if (iterCnt_q == 6'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                y_d     = isMod_q ? remRes : quotRes;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        // A flush abandons the operation and drops any same-cycle start.
        if (flush) begin
            state_d = IDLE;
            y_d     = y_q;
        end

        busy_d = (state_d == CALC) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rem_q     <= 32'd0;
            quot_q    <= 32'd0;
            divisor_q <= 32'd0;
            origA_q   <= 32'd0;
            iterCnt_q <= 6'd0;
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
            divZero_q <= 1'b0;
            isMod_q   <= 1'b0;
            y_q       <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            origA_q   <= origA_d;
            iterCnt_q <= iterCnt_d;
            negQuot_q <= negQuot_d;
            negRem_q  <= negRem_d;
            divZero_q <= divZero_d;
            isMod_q   <= isMod_d;
            y_q       <= y_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign y    = y_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_alu_divider.sv
// Directed bench for alu_divider: vector table plus flush, reset and back-to-back sequences.
module tb_alu_divider;

    localparam logic [1:0] DIVS = 2'b00;
    localparam logic [1:0] DIVU = 2'b01;
    localparam logic [1:0] MODS = 2'b10;
    localparam logic [1:0] MODU = 2'b11;

    typedef struct {
        logic [31:0] opA;
        logic [31:0] opB;
        logic [1:0]  op;
        logic [31:0] expY;
    } vector_t;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  opcode;
    logic        start;
    logic        flush;
    logic [31:0] y;
    logic        busy;
    logic        done;

    int nChecks;
    int nFails;

    alu_divider dut (
        .clk    (clk),
        .reset  (reset),
        .a      (a),
        .b      (b),
        .opcode (opcode),
        .start  (start),
        .flush  (flush),
        .y      (y),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues one start from a negedge; returns at the negedge after the start edge,
    // with the operand inputs scrambled to prove they are only sampled at the start.
    task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB, input logic [1:0] op);
        a      = opA;
        b      = opB;
        opcode = op;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        a      = $urandom;
        b      = $urandom;
        opcode = 2'($urandom_range(0, 3));
    endtask

    // Sample n is the cycle after edge E(n-1); done is due at sample 34.
    task automatic waitDone(output int busyCnt, output int lat, output int overlap);
        busyCnt = 0;
        lat     = 0;
        overlap = 0;
        for (int n = 1; n <= 100; n++) begin
            if (busy) busyCnt++;
            if (busy && done) overlap++;
            if (done) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    vector_t vecs[16];

    initial begin
        int busyCnt;
        int lat;
        int overlap;
        int sawDone;
        int sawBusy;

        nChecks = 0;
        nFails  = 0;
        reset   = 1'b1;
        start   = 1'b0;
        flush   = 1'b0;
        a       = 32'd0;
        b       = 32'd0;
        opcode  = 2'b00;

        vecs[0]  = '{32'd100,       32'd7,         DIVU, 32'd14};
        vecs[1]  = '{32'd100,       32'd7,         MODU, 32'd2};
        vecs[2]  = '{32'hFFFFFFF9,  32'd2,         DIVS, 32'hFFFFFFFD};
        vecs[3]  = '{32'hFFFFFFF9,  32'd2,         MODS, 32'hFFFFFFFF};
        vecs[4]  = '{32'h00001234,  32'd0,         DIVU, 32'hFFFFFFFF};
        vecs[5]  = '{32'h00001234,  32'd0,         MODS, 32'h00001234};
        vecs[6]  = '{32'h80000000,  32'hFFFFFFFF,  DIVS, 32'h80000000};
        vecs[7]  = '{32'h80000000,  32'hFFFFFFFF,  MODS, 32'd0};
        vecs[8]  = '{32'd7,         32'hFFFFFFFE,  DIVS, 32'hFFFFFFFD};
        vecs[9]  = '{32'd7,         32'hFFFFFFFE,  MODS, 32'd1};
        vecs[10] = '{32'hFFFFFF9C,  32'hFFFFFFF9,  DIVS, 32'd14};
        vecs[11] = '{32'hFFFFFF9C,  32'hFFFFFFF9,  MODS, 32'hFFFFFFFE};
        vecs[12] = '{32'hFFFFFFFF,  32'd10,        MODU, 32'd5};
        vecs[13] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  DIVU, 32'd1};
        vecs[14] = '{32'h80000000,  32'd0,         DIVS, 32'hFFFFFFFF};
        vecs[15] = '{32'h80000000,  32'd0,         MODU, 32'h80000000};

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_y", y, 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Each vector after the first starts in the previous DONE cycle.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].opA, vecs[i].opB, vecs[i].op);
            waitDone(busyCnt, lat, overlap);
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd34);
            checkOutput($sformatf("vec%0d_busycycles", i), 32'(busyCnt), 32'd33);
            checkOutput($sformatf("vec%0d_overlap", i), 32'(overlap), 32'd0);
            checkOutput($sformatf("vec%0d_y", i), y, vecs[i].expY);
        end

        @(negedge clk);
        checkOutput("idle_after_done", 32'(done), 32'd0);

        // A start during CALC is ignored; a start in DONE chains without a gap.
        applyStimulus(32'd9, 32'd3, DIVU);
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            if (n == 6) begin
                a      = 32'd100;
                b      = 32'd1;
                opcode = DIVU;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        checkOutput("tput_first_latency", 32'(lat), 32'd34);
        checkOutput("tput_first_y", y, 32'd3);
        applyStimulus(32'd20, 32'd4, DIVU);
        waitDone(busyCnt, lat, overlap);
        checkOutput("tput_second_latency", 32'(lat), 32'd34);
        checkOutput("tput_second_y", y, 32'd5);
        @(negedge clk);

        // Flush at iteration 10.
        applyStimulus(32'd50, 32'd5, DIVU);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_busy", 32'(busy), 32'd0);
        checkOutput("flush_done", 32'(done), 32'd0);
        checkOutput("flush_y_kept", y, 32'd5);
        sawDone = 0;
        sawBusy = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) sawDone++;
            if (busy) sawBusy++;
        end
        checkOutput("flush_no_done", 32'(sawDone), 32'd0);
        checkOutput("flush_no_busy", 32'(sawBusy), 32'd0);

        // Flush and start in the same cycle: nothing starts.
        a      = 32'd8;
        b      = 32'd2;
        opcode = DIVU;
        start  = 1'b1;
        flush  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        flush  = 1'b0;
        checkOutput("flushstart_busy", 32'(busy), 32'd0);
        sawDone = 0;
        sawBusy = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) sawDone++;
            if (busy) sawBusy++;
        end
        checkOutput("flushstart_no_done", 32'(sawDone), 32'd0);
        checkOutput("flushstart_no_busy", 32'(sawBusy), 32'd0);
        checkOutput("flushstart_y_kept", y, 32'd5);

        // Reset at iteration 20 clears every output.
        applyStimulus(32'd50, 32'd5, DIVU);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midreset_y", y, 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_done", 32'(done), 32'd0);

        applyStimulus(32'd50, 32'd5, DIVU);
        waitDone(busyCnt, lat, overlap);
        checkOutput("postreset_latency", 32'(lat), 32'd34);
        checkOutput("postreset_y", y, 32'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
